sram2axi_mo_bridge: RTL

SRAM2AXI_MO_BRIDGE -- requirements
Module: sram2axi_mo_bridge

---
 rtl/sram2axi_mo_bridge.sv | 236 +++++++++++++++++++++++
 1 files changed

// File: rtl/sram2axi_mo_bridge.sv
// rtl/sram2axi_mo_bridge.sv - SRAM-like inst/data ports to AXI bridge with multiple outstanding reads.
// Optional read-after-write address guard: SRAM2AXI_RAW_CHECK_EN.
module sram2axi_mo_bridge #(
    parameter int DATA_W   = 32,
    parameter int RD_OUTST = 2
) (
    input  logic                clk,
    input  logic                reset,

    input  logic                inst_sram_req,
    input  logic                inst_sram_wr,
    input  logic [1:0]          inst_sram_size,
    input  logic [31:0]         inst_sram_addr,
    output logic                inst_sram_addr_ok,
    output logic                inst_sram_data_ok,
    output logic [DATA_W-1:0]   inst_sram_rdata,

    input  logic                data_sram_req,
    input  logic                data_sram_wr,
    input  logic [1:0]          data_sram_size,
    input  logic [DATA_W/8-1:0] data_sram_wstrb,
    input  logic [31:0]         data_sram_addr,
    input  logic [DATA_W-1:0]   data_sram_wdata,
    output logic                data_sram_addr_ok,
    output logic                data_sram_data_ok,
    output logic [DATA_W-1:0]   data_sram_rdata,

    output logic [3:0]          arid,
    output logic [31:0]         araddr,
    output logic [7:0]          arlen,
    output logic [2:0]          arsize,
    output logic [1:0]          arburst,
    output logic [1:0]          arlock,
    output logic [3:0]          arcache,
    output logic [2:0]          arprot,
    output logic                arvalid,
    input  logic                arready,

    input  logic [3:0]          rid,
    input  logic [DATA_W-1:0]   rdata,
    input  logic [1:0]          rresp,
    input  logic                rlast,
    input  logic                rvalid,
    output logic                rready,

    output logic [3:0]          awid,
    output logic [31:0]         awaddr,
    output logic [7:0]          awlen,
    output logic [2:0]          awsize,
    output logic [1:0]          awburst,
    output logic [1:0]          awlock,
    output logic [3:0]          awcache,
    output logic [2:0]          awprot,
    output logic                awvalid,
    input  logic                awready,

    output logic [3:0]          wid,
    output logic [DATA_W-1:0]   wdata,
    output logic [DATA_W/8-1:0] wstrb,
    output logic                wlast,
    output logic                wvalid,
    input  logic                wready,

    input  logic [3:0]          bid,
    input  logic [1:0]          bresp,
    input  logic                bvalid,
    output logic                bready
);

    localparam int CNT_W = $clog2(RD_OUTST + 1);
    localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(RD_OUTST);

    typedef enum logic [1:0] {W_IDLE, W_SEND, W_RESP} wstate_t;

    wstate_t             r_wstate;
    logic                r_awvalid;
    logic                r_wvalid;
    logic [31:0]         r_aw_addr;
    logic [1:0]          r_aw_size;
    logic [DATA_W-1:0]   r_wdata;
    logic [DATA_W/8-1:0] r_wstrb;

    logic                r_ar_valid;
    logic [3:0]          r_ar_id;
    logic [31:0]         r_ar_addr;
    logic [1:0]          r_ar_size;

    logic [CNT_W-1:0]    r_inst_cnt;
    logic [CNT_W-1:0]    r_data_cnt;

    logic w_inst_raw_ok;
    logic w_data_raw_ok;
    logic w_data_wr_acc;
    logic w_data_rd_acc;
    logic w_inst_rd_acc;
    logic w_inst_ret;
    logic w_data_ret;
    logic w_inst_rd_ok;
    logic w_data_rd_ok;
    logic w_wr_done;
    logic w_unused;

`ifdef SRAM2AXI_RAW_CHECK_EN
    assign w_inst_raw_ok = (r_wstate == W_IDLE) || (inst_sram_addr[31:2] != r_aw_addr[31:2]);
    assign w_data_raw_ok = (r_wstate == W_IDLE) || (data_sram_addr[31:2] != r_aw_addr[31:2]);
`else
    assign w_inst_raw_ok = 1'b1;
    assign w_data_raw_ok = 1'b1;
`endif

    // inst_sram_wr is deliberately ignored: the inst port is read-only.
    assign w_data_wr_acc = data_sram_req && data_sram_wr && (r_wstate == W_IDLE);
    assign w_data_rd_acc = data_sram_req && !data_sram_wr && !r_ar_valid
                         && (r_data_cnt < MAX_CNT) && w_data_raw_ok;
    assign w_inst_rd_acc = inst_sram_req && !r_ar_valid && !w_data_rd_acc
                         && (r_inst_cnt < MAX_CNT) && w_inst_raw_ok;

    assign w_inst_rd_ok = rvalid && (rid == 4'd0) && (r_inst_cnt != '0);
    assign w_data_rd_ok = rvalid && (rid == 4'd1) && (r_data_cnt != '0);
    assign w_inst_ret   = w_inst_rd_ok && rlast;
    assign w_data_ret   = w_data_rd_ok && rlast;
    assign w_wr_done    = (r_wstate == W_RESP) && bvalid && (bid == 4'd1);

    assign inst_sram_addr_ok = w_inst_rd_acc;
    assign inst_sram_data_ok = w_inst_rd_ok;
    assign inst_sram_rdata   = rdata;
    assign data_sram_addr_ok = w_data_wr_acc || w_data_rd_acc;
    assign data_sram_data_ok = w_data_rd_ok || w_wr_done;
    assign data_sram_rdata   = rdata;

    assign arid    = r_ar_id;
    assign araddr  = r_ar_addr;
    assign arlen   = 8'd0;
    assign arsize  = {1'b0, r_ar_size};
    assign arburst = 2'b01;
    assign arlock  = 2'd0;
    assign arcache = 4'd0;
    assign arprot  = 3'd0;
    assign arvalid = r_ar_valid;
    assign rready  = 1'b1;

    assign awid    = 4'd1;
    assign awaddr  = r_aw_addr;
    assign awlen   = 8'd0;
    assign awsize  = {1'b0, r_aw_size};
    assign awburst = 2'b01;
    assign awlock  = 2'd0;
    assign awcache = 4'd0;
    assign awprot  = 3'd0;
    assign awvalid = r_awvalid;
    assign wid     = 4'd1;
    assign wdata   = r_wdata;
    assign wstrb   = r_wstrb;
    assign wlast   = 1'b1;
    assign wvalid  = r_wvalid;
    assign bready  = 1'b1;

    assign w_unused = &{1'b0, inst_sram_wr, rresp, bresp};

    always_ff @(posedge clk) begin
        if (reset) begin
            r_ar_valid <= 1'b0;
            r_ar_id    <= 4'd0;
            r_ar_addr  <= 32'd0;
            r_ar_size  <= 2'd0;
        end else if (w_data_rd_acc) begin
            r_ar_valid <= 1'b1;
            r_ar_id    <= 4'd1;
            r_ar_addr  <= data_sram_addr;
            r_ar_size  <= data_sram_size;
        end else if (w_inst_rd_acc) begin
            r_ar_valid <= 1'b1;
            r_ar_id    <= 4'd0;
            r_ar_addr  <= inst_sram_addr;
            r_ar_size  <= inst_sram_size;
        end else if (r_ar_valid && arready) begin
            r_ar_valid <= 1'b0;
        end
    end

    // Returns on a zero counter are stale beats and never decrement.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_inst_cnt <= '0;
            r_data_cnt <= '0;
        end else begin
            case ({w_inst_rd_acc, w_inst_ret})
                2'b10:   r_inst_cnt <= r_inst_cnt + 1'b1;
                2'b01:   r_inst_cnt <= r_inst_cnt - 1'b1;
                default: r_inst_cnt <= r_inst_cnt;
            endcase
            case ({w_data_rd_acc, w_data_ret})
                2'b10:   r_data_cnt <= r_data_cnt + 1'b1;
                2'b01:   r_data_cnt <= r_data_cnt - 1'b1;
                default: r_data_cnt <= r_data_cnt;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_wstate  <= W_IDLE;
            r_awvalid <= 1'b0;
            r_wvalid  <= 1'b0;
            r_aw_addr <= 32'd0;
            r_aw_size <= 2'd0;
            r_wdata   <= '0;
            r_wstrb   <= '0;
        end else begin
            case (r_wstate)
                W_IDLE: begin
                    if (w_data_wr_acc) begin
                        r_wstate  <= W_SEND;
                        r_awvalid <= 1'b1;
                        r_wvalid  <= 1'b1;
                        r_aw_addr <= data_sram_addr;
                        r_aw_size <= data_sram_size;
                        r_wdata   <= data_sram_wdata;
                        r_wstrb   <= data_sram_wstrb;
                    end
                end
                W_SEND: begin
                    if (r_awvalid && awready) r_awvalid <= 1'b0;
                    if (r_wvalid && wready)   r_wvalid  <= 1'b0;
                    if ((!r_awvalid || awready) && (!r_wvalid || wready))
                        r_wstate <= W_RESP;
                end
                W_RESP: begin
                    if (w_wr_done) r_wstate <= W_IDLE;
                end
                default: r_wstate <= W_IDLE;
            endcase
        end
    end

endmodule
